// File: rtl/rv32i_writeback.sv
// RV32I writeback stage: load extension, load-over-ALU arbitration onto the register-file
// write port, and a pending-write scoreboard. Define WB_FWD_EN to enable commit forwarding.
module rv32i_writeback #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            iss_valid_i,
  input  logic [4:0]      iss_rd_addr_i,
  output logic            iss_ready_o,
  input  logic            alu_valid_i,
  input  logic [4:0]      alu_rd_addr_i,
  input  logic [XLEN-1:0] alu_data_i,
  output logic            alu_ready_o,
  input  logic            ld_valid_i,
  input  logic [4:0]      ld_rd_addr_i,
  input  logic [XLEN-1:0] ld_data_i,
  input  logic [2:0]      ld_funct3_i,
  input  logic [1:0]      ld_byte_off_i,
  output logic            ld_ready_o,
  output logic [4:0]      rd_addr_o,
  output logic            wr_en_o,
  output logic [XLEN-1:0] wr_data_o,
  output logic [NREG-1:0] busy_o,
  output logic            ld_err_o,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  output logic            rs1_fwd_hit_o,
  output logic            rs2_fwd_hit_o,
  output logic [XLEN-1:0] rs1_fwd_data_o,
  output logic [XLEN-1:0] rs2_fwd_data_o
);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] ld_ext;
  logic            ld_bad;
  logic            alu_fire;
  logic            xfer;
  logic            xfer_bad;
  logic [4:0]      xfer_rd;
  logic [XLEN-1:0] xfer_data;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;
  logic            clr_pend;
  logic [4:0]      clr_idx;

  always_comb begin
    byte_sel = ld_data_i[{ld_byte_off_i, 3'b000} +: 8];
    half_sel = ld_byte_off_i[1] ? ld_data_i[31:16] : ld_data_i[15:0];
    ld_ext   = '0;
    ld_bad   = 1'b0;
    case (ld_funct3_i)
      F3_LB:  ld_ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LH: begin
        ld_ext = {{(XLEN-16){half_sel[15]}}, half_sel};
        ld_bad = ld_byte_off_i[0];
      end
      F3_LW: begin
        ld_ext = ld_data_i;
        ld_bad = (ld_byte_off_i != 2'b00);
      end
      F3_LBU: ld_ext = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LHU: begin
        ld_ext = {{(XLEN-16){1'b0}}, half_sel};
        ld_bad = ld_byte_off_i[0];
      end
      default: ld_bad = 1'b1;
    endcase
  end

  // The load is older than any ALU result it collides with, so it always wins.
  assign ld_ready_o  = 1'b1;
  assign alu_ready_o = ~ld_valid_i;
  assign alu_fire    = alu_valid_i & ~ld_valid_i;
  assign xfer        = ld_valid_i | alu_fire;
  assign xfer_bad    = ld_valid_i & ld_bad;
  assign xfer_rd     = ld_valid_i ? ld_rd_addr_i : alu_rd_addr_i;
  assign xfer_data   = ld_valid_i ? ld_ext : alu_data_i;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_addr_o <= '0;
      wr_en_o   <= 1'b0;
      wr_data_o <= '0;
      ld_err_o  <= 1'b0;
      clr_pend  <= 1'b0;
      clr_idx   <= '0;
    end else begin
      wr_en_o  <= xfer & ~xfer_bad & (xfer_rd != 5'd0);
      ld_err_o <= xfer_bad;
      clr_pend <= xfer;
      if (xfer) begin
        rd_addr_o <= xfer_rd;
        wr_data_o <= xfer_data;
        clr_idx   <= xfer_rd;
      end
    end
  end

  // Clears land one edge after the commit, so busy drops the cycle after wr_en_o.
  assign iss_ready_o = (iss_rd_addr_i == 5'd0) | ~busy[iss_rd_addr_i];

  always_comb begin
    busy_next = busy;
    if (clr_pend)
      busy_next[clr_idx] = 1'b0;
    if (iss_valid_i && iss_ready_o)
      busy_next[iss_rd_addr_i] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      busy <= '0;
    else
      busy <= busy_next;
  end

  assign busy_o = busy;

`ifdef WB_FWD_EN
  assign rs1_fwd_hit_o  = wr_en_o & (rd_addr_o == rs1_addr_i) & (rs1_addr_i != 5'd0);
  assign rs2_fwd_hit_o  = wr_en_o & (rd_addr_o == rs2_addr_i) & (rs2_addr_i != 5'd0);
  assign rs1_fwd_data_o = wr_data_o;
  assign rs2_fwd_data_o = wr_data_o;
`else
  logic unused_fwd;
  assign unused_fwd     = ^{rs1_addr_i, rs2_addr_i};
  assign rs1_fwd_hit_o  = 1'b0;
  assign rs2_fwd_hit_o  = 1'b0;
  assign rs1_fwd_data_o = '0;
  assign rs2_fwd_data_o = '0;
`endif

endmodule

// File: tb/tb_rv32i_writeback.sv
// Self-checking bench for rv32i_writeback: directed spot checks plus randomized traffic
// compared every cycle against a behavioural model of commit, load extension and scoreboard.
module tb_rv32i_writeback;

  logic        clock;
  logic        reset;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [2:0]  ld_f3;
  logic [1:0]  ld_off;
  logic        ld_ready;
  logic [4:0]  rd_addr;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [31:0] busy;
  logic        ld_err;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_hit;
  logic        rs2_hit;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  int checks = 0;
  int errors = 0;

  rv32i_writeback #(.XLEN(32), .NREG(32)) dut (
    .clock(clock), .reset(reset),
    .iss_valid_i(iss_valid), .iss_rd_addr_i(iss_rd), .iss_ready_o(iss_ready),
    .alu_valid_i(alu_valid), .alu_rd_addr_i(alu_rd), .alu_data_i(alu_data),
    .alu_ready_o(alu_ready),
    .ld_valid_i(ld_valid), .ld_rd_addr_i(ld_rd), .ld_data_i(ld_data),
    .ld_funct3_i(ld_f3), .ld_byte_off_i(ld_off), .ld_ready_o(ld_ready),
    .rd_addr_o(rd_addr), .wr_en_o(wr_en), .wr_data_o(wr_data), .busy_o(busy),
    .ld_err_o(ld_err),
    .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
    .rs1_fwd_hit_o(rs1_hit), .rs2_fwd_hit_o(rs2_hit),
    .rs1_fwd_data_o(rs1_data), .rs2_fwd_data_o(rs2_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {error, extended value} straight from the load-type rules.
  function automatic logic [32:0] ext_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [31:0] s;
    int v;
    s = w >> (off * 8);
    case (f3)
      3'd0: begin v = $signed(s[7:0]);  return {1'b0, 32'(v)}; end
      3'd1: begin v = $signed(s[15:0]); return {off[0], 32'(v)}; end
      3'd2: return {off != 2'd0, w};
      3'd4: return {1'b0, s & 32'h0000_00FF};
      3'd5: return {off[0], s & 32'h0000_FFFF};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  logic        m_wr_en;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic        m_err;
  logic [31:0] m_busy;
  logic        m_clr;
  logic [4:0]  m_clr_idx;

  always @(posedge clock or posedge reset) begin
    logic [32:0] r;
    logic [31:0] b;
    logic        take;
    logic        bad;
    logic [4:0]  t_rd;
    if (reset) begin
      m_wr_en <= 1'b0; m_rd <= '0; m_data <= '0; m_err <= 1'b0;
      m_busy <= '0; m_clr <= 1'b0; m_clr_idx <= '0;
    end else begin
      r = ext_load(ld_data, ld_f3, ld_off);
      b = m_busy;
      if (m_clr) b[m_clr_idx] = 1'b0;
      if (iss_valid && iss_rd != 5'd0 && !m_busy[iss_rd]) b[iss_rd] = 1'b1;
      m_busy <= b;
      take = ld_valid || alu_valid;
      bad  = ld_valid && r[32];
      t_rd = ld_valid ? ld_rd : alu_rd;
      m_wr_en <= take && !bad && t_rd != 5'd0;
      m_err   <= bad;
      m_clr   <= take;
      if (take) begin
        m_rd      <= t_rd;
        m_data    <= ld_valid ? r[31:0] : alu_data;
        m_clr_idx <= t_rd;
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      check("wr_en", {31'b0, wr_en}, {31'b0, m_wr_en});
      if (m_wr_en) begin
        check("rd_addr", {27'b0, rd_addr}, {27'b0, m_rd});
        check("wr_data", wr_data, m_data);
      end
      check("ld_err", {31'b0, ld_err}, {31'b0, m_err});
      check("busy", busy, m_busy);
      check("ld_ready", {31'b0, ld_ready}, 32'd1);
      check("alu_ready", {31'b0, alu_ready}, {31'b0, !ld_valid});
      check("iss_ready", {31'b0, iss_ready}, {31'b0, (iss_rd == 5'd0) || !m_busy[iss_rd]});
`ifdef WB_FWD_EN
      check("rs1_hit", {31'b0, rs1_hit}, {31'b0, m_wr_en && m_rd == rs1_addr && rs1_addr != 0});
      check("rs2_hit", {31'b0, rs2_hit}, {31'b0, m_wr_en && m_rd == rs2_addr && rs2_addr != 0});
      if (m_wr_en) begin
        check("rs1_data", rs1_data, m_data);
        check("rs2_data", rs2_data, m_data);
      end
`else
      check("rs1_hit", {31'b0, rs1_hit}, 32'd0);
      check("rs2_hit", {31'b0, rs2_hit}, 32'd0);
      check("rs1_data", rs1_data, 32'd0);
      check("rs2_data", rs2_data, 32'd0);
`endif
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic peek();
    @(negedge clock);
    #1;
  endtask

  task automatic idle();
    iss_valid = 1'b0;
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
  endtask

  task automatic apply_load(input logic [4:0] rd, input logic [31:0] d, input logic [2:0] f3,
                            input logic [1:0] off);
    ld_valid = 1'b1; ld_rd = rd; ld_data = d; ld_f3 = f3; ld_off = off;
  endtask

  task automatic apply_alu(input logic [4:0] rd, input logic [31:0] d);
    alu_valid = 1'b1; alu_rd = rd; alu_data = d;
  endtask

  task automatic apply_stimulus(input int cycles);
    logic alu_taken;
    logic iss_taken;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      alu_taken = alu_ready;
      iss_taken = iss_ready;
      tick();
      if (!(alu_valid && !alu_taken)) begin
        alu_valid = ($urandom_range(1) == 1);
        alu_rd    = 5'($urandom_range(7));
        alu_data  = $urandom;
      end
      if (!(iss_valid && !iss_taken)) begin
        iss_valid = ($urandom_range(1) == 1);
        iss_rd    = 5'($urandom_range(7));
      end
      ld_valid = ($urandom_range(2) == 0);
      ld_rd    = 5'($urandom_range(7));
      ld_data  = $urandom;
      ld_f3    = 3'($urandom_range(7));
      ld_off   = 2'($urandom_range(3));
      rs1_addr = 5'($urandom_range(7));
      rs2_addr = 5'($urandom_range(7));
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    check(name, act, exp);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    iss_rd = '0; alu_rd = '0; alu_data = '0; ld_rd = '0; ld_data = '0;
    ld_f3 = '0; ld_off = '0; rs1_addr = '0; rs2_addr = '0;
    tick();
    tick();
    check_output("reset_wr_en", {31'b0, wr_en}, 32'd0);
    check_output("reset_busy", busy, 32'd0);
    check_output("reset_wr_data", wr_data, 32'd0);
    reset = 1'b0;
    peek();

    apply_load(5'd5, 32'h80FF_1234, 3'b000, 2'd2);
    tick(); idle(); peek();
    check_output("lb_en", {31'b0, wr_en}, 32'd1);
    check_output("lb_rd", {27'b0, rd_addr}, 32'd5);
    check_output("lb_data", wr_data, 32'hFFFF_FFFF);
    apply_load(5'd5, 32'h80FF_1234, 3'b100, 2'd2);
    tick(); idle(); peek();
    check_output("lbu_data", wr_data, 32'h0000_00FF);
    apply_load(5'd5, 32'h80FF_1234, 3'b001, 2'd2);
    tick(); idle(); peek();
    check_output("lh_data", wr_data, 32'hFFFF_80FF);
    apply_load(5'd5, 32'h80FF_1234, 3'b101, 2'd0);
    tick(); idle(); peek();
    check_output("lhu_data", wr_data, 32'h0000_1234);

    apply_alu(5'd3, 32'h11);
    apply_load(5'd4, 32'h22, 3'b010, 2'd0);
    #1;
    check_output("arb_alu_ready", {31'b0, alu_ready}, 32'd0);
    tick(); ld_valid = 1'b0; peek();
    check_output("arb_first_rd", {27'b0, rd_addr}, 32'd4);
    check_output("arb_first_data", wr_data, 32'h22);
    tick(); idle(); peek();
    check_output("arb_second_rd", {27'b0, rd_addr}, 32'd3);
    check_output("arb_second_data", wr_data, 32'h11);

    iss_valid = 1'b1; iss_rd = 5'd7;
    tick(); peek();
    check_output("waw_stall", {31'b0, iss_ready}, 32'd0);
    apply_alu(5'd7, 32'h77);
    tick(); alu_valid = 1'b0; peek();
    check_output("waw_commit_rd", {27'b0, rd_addr}, 32'd7);
    check_output("waw_still_busy", {31'b0, busy[7]}, 32'd1);
    tick(); peek();
    check_output("waw_cleared", {31'b0, busy[7]}, 32'd0);
    check_output("waw_ready", {31'b0, iss_ready}, 32'd1);
    tick(); idle(); peek();
    check_output("waw_rereserved", {31'b0, busy[7]}, 32'd1);

    apply_alu(5'd6, 32'h66);
    tick(); alu_valid = 1'b0; iss_valid = 1'b1; iss_rd = 5'd6;
    tick(); idle(); peek();
    check_output("set_wins", {31'b0, busy[6]}, 32'd1);
    apply_alu(5'd6, 32'h66);
    tick(); idle(); tick(); peek();
    check_output("x6_cleared", {31'b0, busy[6]}, 32'd0);

    apply_alu(5'd0, 32'hDEAD);
    iss_valid = 1'b1; iss_rd = 5'd0;
    #1;
    check_output("x0_iss_ready", {31'b0, iss_ready}, 32'd1);
    tick(); idle(); peek();
    check_output("x0_no_write", {31'b0, wr_en}, 32'd0);
    check_output("x0_busy", {31'b0, busy[0]}, 32'd0);

    iss_valid = 1'b1; iss_rd = 5'd9;
    tick(); idle();
    apply_load(5'd9, 32'h1234_5678, 3'b010, 2'd1);
    tick(); idle(); peek();
    check_output("err_pulse", {31'b0, ld_err}, 32'd1);
    check_output("err_no_write", {31'b0, wr_en}, 32'd0);
    tick(); peek();
    check_output("err_pulse_end", {31'b0, ld_err}, 32'd0);
    check_output("err_busy_clear", {31'b0, busy[9]}, 32'd0);

    iss_valid = 1'b1; iss_rd = 5'd9;
    tick(); idle();
    apply_alu(5'd3, 32'h33);
    tick(); idle(); peek();
    check_output("pre_reset_busy", busy, 32'h0000_0280);
    check_output("pre_reset_wr_en", {31'b0, wr_en}, 32'd1);
    reset = 1'b1;
    #1;
    check_output("async_wr_en", {31'b0, wr_en}, 32'd0);
    check_output("async_busy", busy, 32'd0);
    check_output("async_rd", {27'b0, rd_addr}, 32'd0);
    check_output("async_data", wr_data, 32'd0);
    tick();
    reset = 1'b0;
    peek();

    apply_alu(5'd12, 32'hCAFE);
    rs1_addr = 5'd12;
    tick(); idle(); peek();
`ifdef WB_FWD_EN
    check_output("fwd_hit", {31'b0, rs1_hit}, 32'd1);
    check_output("fwd_data", rs1_data, 32'h0000_CAFE);
`else
    check_output("fwd_hit_off", {31'b0, rs1_hit}, 32'd0);
    check_output("fwd_data_off", rs1_data, 32'd0);
`endif

    apply_stimulus(3000);
    idle();
    tick();
    peek();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
